// File: rtl/alu_exec_pkg.sv
// Shared constants for the ALU execute stage: widths, ARM opcodes, flag indices,
// FSM encodings and small decode helpers.
package alu_exec_pkg;

  localparam int ALUAW  = 4;
  localparam int FLAGSW = 4;

  localparam logic [ALUAW-1:0] OP_AND = 4'h0;
  localparam logic [ALUAW-1:0] OP_EOR = 4'h1;
  localparam logic [ALUAW-1:0] OP_SUB = 4'h2;
  localparam logic [ALUAW-1:0] OP_RSB = 4'h3;
  localparam logic [ALUAW-1:0] OP_ADD = 4'h4;
  localparam logic [ALUAW-1:0] OP_ADC = 4'h5;
  localparam logic [ALUAW-1:0] OP_SBC = 4'h6;
  localparam logic [ALUAW-1:0] OP_RSC = 4'h7;
  localparam logic [ALUAW-1:0] OP_TST = 4'h8;
  localparam logic [ALUAW-1:0] OP_TEQ = 4'h9;
  localparam logic [ALUAW-1:0] OP_CMP = 4'hA;
  localparam logic [ALUAW-1:0] OP_CMN = 4'hB;
  localparam logic [ALUAW-1:0] OP_ORR = 4'hC;
  localparam logic [ALUAW-1:0] OP_MOV = 4'hD;
  localparam logic [ALUAW-1:0] OP_BIC = 4'hE;
  localparam logic [ALUAW-1:0] OP_MVN = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Compare/test ops (TST, TEQ, CMP, CMN) only touch the flags.
  function automatic logic op_writes_rd(input logic [ALUAW-1:0] op);
    return (op[3:2] != 2'b10);
  endfunction

  function automatic logic op_is_arith(input logic [ALUAW-1:0] op);
    return (op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN});
  endfunction

  function automatic logic [FLAGSW-1:0] merge_flags(input logic [FLAGSW-1:0] mask,
                                                    input logic [FLAGSW-1:0] old,
                                                    input logic n, input logic z,
                                                    input logic c, input logic v);
    logic [FLAGSW-1:0] nf;
    nf         = '0;
    nf[FLAG_N] = n;
    nf[FLAG_Z] = z;
    nf[FLAG_C] = c;
    nf[FLAG_V] = v;
    return (nf & mask) | (old & ~mask);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ARM data-processing datapath: opcode -> result, carry-out, overflow.
// Subtracts are folded into one adder as x + ~y + carry_in.
module alu_core
  import alu_exec_pkg::*;
(
  input  logic [ALUAW-1:0] opcode,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             shifter_carry,
  output logic [31:0]      result,
  output logic             c_out,
  output logic             v_out
);

  logic [31:0] x;
  logic [31:0] y;
  logic        cin;
  logic [32:0] sum;
  logic        arith;

  always_comb begin
    x   = a;
    y   = b;
    cin = 1'b0;
    case (opcode)
      OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
      OP_ADC:         cin = c_in;
      OP_SBC:         begin y = ~b; cin = c_in; end
      OP_RSC:         begin x = b; y = ~a; cin = c_in; end
      default:        ;
    endcase
  end

  assign sum   = {1'b0, x} + {1'b0, y} + {32'b0, cin};
  assign arith = op_is_arith(opcode);

  always_comb begin
    case (opcode)
      OP_AND, OP_TST: result = a & b;
      OP_EOR, OP_TEQ: result = a ^ b;
      OP_ORR:         result = a | b;
      OP_MOV:         result = b;
      OP_BIC:         result = a & ~b;
      OP_MVN:         result = ~b;
      default:        result = sum[31:0];
    endcase
  end

  // Carry is "no borrow" for subtracts because of the inverted-operand form.
  assign c_out = arith ? sum[32] : shifter_carry;
  assign v_out = arith ? ((x[31] == y[31]) && (sum[31] != x[31])) : v_in;

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: IDLE/BUSY/DONE handshake FSM, CPSR flag register and an
// optional 32-cycle shift-add multiplier enabled by defining MUL_EN.
// Handshake: an op transfers when in_valid & in_ready; a result transfers when
// out_valid & out_ready, and DONE holds all outputs stable until it does.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALUAW-1:0]  alu_opcode,
  input  logic [FLAGSW-1:0] should_set_cpsr,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic              shifter_carry,
  input  logic              is_mul,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              result_we,
  output logic [FLAGSW-1:0] cpsr_flags,
  output logic [1:0]        dbg_state
);

  logic [1:0]  state;
  logic        accept;
  logic        start_mul;
  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_v;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  alu_core u_core (
    .opcode        (alu_opcode),
    .a             (op_a),
    .b             (op_b),
    .c_in          (cpsr_flags[FLAG_C]),
    .v_in          (cpsr_flags[FLAG_V]),
    .shifter_carry (shifter_carry),
    .result        (alu_res),
    .c_out         (alu_c),
    .v_out         (alu_v)
  );

`ifdef MUL_EN
  logic [31:0]       mcand;
  logic [31:0]       mplier;
  logic [31:0]       acc;
  logic [5:0]        mcnt;
  logic [FLAGSW-1:0] mmask;
  logic              mul_done;

  assign start_mul = accept && is_mul;
  assign mul_done  = (mcnt == 6'd32);

  // One multiplier bit per BUSY cycle; the commit happens on the cycle after the 32nd step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      mcnt   <= '0;
      mmask  <= '0;
    end else if (start_mul) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      mcnt   <= '0;
      mmask  <= should_set_cpsr;
    end else if ((state == ST_BUSY) && !mul_done) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      mcnt   <= mcnt + 6'd1;
    end
  end
`else
  logic unused_mul;
  assign unused_mul = is_mul;
  assign start_mul  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      result     <= '0;
      result_we  <= 1'b0;
      cpsr_flags <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (start_mul) begin
              state <= ST_BUSY;
            end else begin
              state      <= ST_DONE;
              result     <= alu_res;
              result_we  <= op_writes_rd(alu_opcode);
              cpsr_flags <= merge_flags(should_set_cpsr, cpsr_flags,
                                        alu_res[31], (alu_res == 32'd0), alu_c, alu_v);
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
`ifdef MUL_EN
          if (mul_done) begin
            state      <= ST_DONE;
            result     <= acc;
            result_we  <= 1'b1;
            // Multiply never writes C or V.
            cpsr_flags <= merge_flags(mmask & 4'b1100, cpsr_flags,
                                      acc[31], (acc == 32'd0), 1'b0, 1'b0);
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
